// File: rtl/his_builder_pp.sv
// Histogram builder: clear, accumulate events with a forwarded 2-stage RMW, then stream bins out.
// Optional HIS_PEAK_DETECT_EN adds peak_bin/peak_count tracking of the largest bin.
module his_builder_pp #(
  parameter int BIN_W = 8,
  parameter int CNT_W = 12,
  parameter int CYC_W = 16
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic [CYC_W-1:0] cyc_num,
  input  logic             cyc_end,
  input  logic             ev_valid,
  input  logic [BIN_W-1:0] ev_bin,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [BIN_W-1:0] rd_bin,
  output logic [CNT_W-1:0] rd_count,
  output logic             rd_last,
  output logic             busy,
  output logic             his_done,
  output logic             ev_drop
`ifdef HIS_PEAK_DETECT_EN
  , output logic [BIN_W-1:0] peak_bin
  , output logic [CNT_W-1:0] peak_count
`endif
);
  localparam int NUM_BINS = 2**BIN_W;
  localparam logic [BIN_W-1:0] LAST_BIN = '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ACCUM, S_DRAIN, S_READOUT} state_t;
  state_t state, state_nx;

  // ptr walks the bins during CLEAR and is the displayed bin during READOUT
  logic [BIN_W-1:0] ptr;
  logic [CYC_W-1:0] cyc_lat, cyc_cnt;
  logic             drain_cnt;
  logic             xfer, ev_acc, last_cyc;

  logic [CNT_W-1:0] mem [NUM_BINS];
  logic [CNT_W-1:0] mem_q, mem_wd;
  logic [BIN_W-1:0] mem_wa, mem_ra;
  logic             mem_we;

  logic             p1_vld, p2_vld;
  logic [BIN_W-1:0] p1_bin, p2_bin;
  logic [CNT_W-1:0] p2_val, base, wb_val;

  assign xfer     = rd_valid & rd_ready;
  assign ev_acc   = ev_valid && (state == S_ACCUM);
  assign last_cyc = (state == S_ACCUM) && cyc_end && ((cyc_cnt + 1'b1) == cyc_lat);

  assign busy     = (state != S_IDLE);
  assign rd_bin   = ptr;
  assign rd_last  = rd_valid && (ptr == LAST_BIN);
  assign rd_count = rd_valid ? mem_q : '0;

  always_ff @(posedge clk or posedge res) begin
    if (res) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (start) state_nx = S_CLEAR;
      S_CLEAR:   if (ptr == LAST_BIN) state_nx = S_ACCUM;
      S_ACCUM:   if (last_cyc) state_nx = S_DRAIN;
      S_DRAIN:   if (drain_cnt) state_nx = S_READOUT;
      S_READOUT: if (xfer && ptr == LAST_BIN) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      ptr       <= '0;
      cyc_lat   <= '0;
      cyc_cnt   <= '0;
      drain_cnt <= 1'b0;
      rd_valid  <= 1'b0;
      his_done  <= 1'b0;
      ev_drop   <= 1'b0;
    end else begin
      his_done  <= xfer && rd_last;
      ev_drop   <= ev_valid && (state != S_ACCUM);
      drain_cnt <= (state == S_DRAIN) ? ~drain_cnt : 1'b0;
      case (state)
        S_IDLE: if (start) begin
          ptr     <= '0;
          cyc_cnt <= '0;
          cyc_lat <= (cyc_num == '0) ? CYC_W'(1) : cyc_num;
        end
        S_CLEAR: ptr <= ptr + 1'b1;
        S_ACCUM: if (cyc_end) cyc_cnt <= cyc_cnt + 1'b1;
        S_READOUT: begin
          // first cycle only primes the read; ptr wraps to 0 after the last bin
          if (!rd_valid) rd_valid <= 1'b1;
          else if (rd_ready) begin
            ptr <= ptr + 1'b1;
            if (ptr == LAST_BIN) rd_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // write-back from stage 1 lands at the same edge stage 0 reads, so stage 2 forwards it
  assign base   = (p2_vld && p2_bin == p1_bin) ? p2_val : mem_q;
  assign wb_val = (base == CNT_MAX) ? base : base + 1'b1;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      p1_vld <= 1'b0;
      p1_bin <= '0;
      p2_vld <= 1'b0;
      p2_bin <= '0;
      p2_val <= '0;
    end else begin
      p1_vld <= ev_acc;
      p1_bin <= ev_bin;
      p2_vld <= p1_vld;
      p2_bin <= p1_bin;
      p2_val <= wb_val;
    end
  end

  always_comb begin
    mem_we = (state == S_CLEAR) || p1_vld;
    mem_wa = (state == S_CLEAR) ? ptr : p1_bin;
    mem_wd = (state == S_CLEAR) ? '0 : wb_val;
    mem_ra = ev_bin;
    // during readout, look one bin ahead on a transfer so rd_count is ready next cycle
    if (state == S_READOUT) mem_ra = xfer ? ptr + 1'b1 : ptr;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
    mem_q <= mem[mem_ra];
  end

`ifdef HIS_PEAK_DETECT_EN
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      peak_bin   <= '0;
      peak_count <= '0;
    end else if (state == S_CLEAR) begin
      peak_bin   <= '0;
      peak_count <= '0;
    end else if (p1_vld && wb_val > peak_count) begin
      peak_bin   <= p1_bin;
      peak_count <= wb_val;
    end
  end
`endif

endmodule

// File: tb/tb_his_builder_pp.sv
// Directed bench for his_builder_pp: a default instance and a CNT_W=4 instance share stimulus.
module tb_his_builder_pp;
  localparam int NB = 256;

  logic        clk = 1'b0, res = 1'b1, start = 1'b0, cyc_end = 1'b0;
  logic        ev_valid = 1'b0, rd_ready = 1'b0;
  logic [15:0] cyc_num = '0;
  logic [7:0]  ev_bin = '0;

  logic        rd_valid, rd_last, busy, his_done, ev_drop;
  logic [7:0]  rd_bin;
  logic [11:0] rd_count;
  logic        rd_valid_s, rd_last_s, busy_s, his_done_s, ev_drop_s;
  logic [7:0]  rd_bin_s;
  logic [3:0]  rd_count_s;
`ifdef HIS_PEAK_DETECT_EN
  logic [7:0]  peak_bin, peak_bin_s;
  logic [11:0] peak_count;
  logic [3:0]  peak_count_s;
`endif

  his_builder_pp u_dut (
    .clk(clk), .res(res), .start(start), .cyc_num(cyc_num), .cyc_end(cyc_end),
    .ev_valid(ev_valid), .ev_bin(ev_bin), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_bin(rd_bin), .rd_count(rd_count), .rd_last(rd_last),
    .busy(busy), .his_done(his_done), .ev_drop(ev_drop)
`ifdef HIS_PEAK_DETECT_EN
    , .peak_bin(peak_bin), .peak_count(peak_count)
`endif
  );

  his_builder_pp #(.CNT_W(4)) u_sat (
    .clk(clk), .res(res), .start(start), .cyc_num(cyc_num), .cyc_end(cyc_end),
    .ev_valid(ev_valid), .ev_bin(ev_bin), .rd_ready(rd_ready),
    .rd_valid(rd_valid_s), .rd_bin(rd_bin_s), .rd_count(rd_count_s), .rd_last(rd_last_s),
    .busy(busy_s), .his_done(his_done_s), .ev_drop(ev_drop_s)
`ifdef HIS_PEAK_DETECT_EN
    , .peak_bin(peak_bin_s), .peak_count(peak_count_s)
`endif
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int got [NB];
  int got_s [NB];
  int exp_c [NB];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // one event (optionally with cyc_end); ev_drop is checked one cycle later
  task automatic ev(input int bin, input bit ce, input bit exp_drop);
    ev_valid = 1'b1; ev_bin = 8'(bin); cyc_end = ce;
    @(posedge clk); #1;
    ev_valid = 1'b0; cyc_end = 1'b0;
    chk("ev_drop", ev_drop, exp_drop);
  endtask

  task automatic cend();
    cyc_end = 1'b1;
    @(posedge clk); #1;
    cyc_end = 1'b0;
  endtask

  // returns in the first ACCUM cycle; an event with cyc_end in the last CLEAR cycle must be ignored
  task automatic do_start(input int cn);
    cyc_num = 16'(cn); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_clear", busy, 1);
`ifdef HIS_PEAK_DETECT_EN
    chk("peak_clear", peak_count, 0);
`endif
    repeat (NB - 1) @(posedge clk);
    #1;
    ev(3, 1'b1, 1'b1);
    chk("busy_accum", busy, 1);
  endtask

  task automatic readout(input bit rnd, input int exp_lat);
    int n, lat, cyc, ord_err, stall_err, last_err;
    bit done, pstall;
    logic [7:0] pb;
    logic [11:0] pc;
    logic pl;
    n = 0; lat = -1; cyc = 0; ord_err = 0; stall_err = 0; last_err = 0;
    done = 1'b0; pstall = 1'b0; pb = '0; pc = '0; pl = 1'b0;
    for (int i = 0; i < NB; i++) begin got[i] = -1; got_s[i] = -1; end
    while (!done && cyc < 3000) begin
      @(posedge clk); #1;
      rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      cyc++;
      if (rd_valid && lat < 0) lat = cyc;
      if (pstall && (!rd_valid || rd_bin !== pb || rd_count !== pc || rd_last !== pl)) stall_err++;
      if (rd_valid_s !== rd_valid || rd_bin_s !== rd_bin) ord_err++;
      if (rd_valid && rd_ready) begin
        if (int'(rd_bin) != n) ord_err++;
        if (rd_last != (n == NB - 1)) last_err++;
        got[rd_bin] = int'(rd_count);
        got_s[rd_bin] = int'(rd_count_s);
        n++;
        if (rd_last) done = 1'b1;
      end
      pstall = rd_valid && !rd_ready;
      pb = rd_bin; pc = rd_count; pl = rd_last;
    end
    chk("ro_done", done, 1);
    chk("ro_count", n, NB);
    chk("ro_order", ord_err, 0);
    chk("ro_last", last_err, 0);
    chk("ro_stall", stall_err, 0);
    chk("ro_latency", lat, exp_lat);
    @(posedge clk); #1;
    rd_ready = 1'b0;
    chk("his_done_hi", his_done, 1);
    chk("busy_end", busy, 0);
    chk("rd_valid_end", rd_valid, 0);
    @(posedge clk); #1;
    chk("his_done_lo", his_done, 0);
  endtask

  task automatic cmp_bins(input string tag);
    int e, es;
    e = 0; es = 0;
    for (int i = 0; i < NB; i++) begin
      if (got[i] != exp_c[i]) e++;
      if (got_s[i] != ((exp_c[i] > 15) ? 15 : exp_c[i])) es++;
    end
    chk(tag, e, 0);
    chk({tag, "_sat"}, es, 0);
  endtask

  task automatic clr_exp();
    for (int i = 0; i < NB; i++) exp_c[i] = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_rd_bin", rd_bin, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_his_done", his_done, 0);
    chk("rst_ev_drop", ev_drop, 0);
    res = 1'b0;
    @(posedge clk); #1;
    ev(50, 1'b1, 1'b1);
    chk("idle_busy", busy, 0);

    // basic run; a start during ACCUM must not restart the acquisition
    do_start(3);
    ev(5, 1'b0, 1'b0); ev(5, 1'b0, 1'b0); ev(5, 1'b0, 1'b0); ev(9, 1'b0, 1'b0);
    start = 1'b1; cyc_num = 16'd9;
    cend();
    start = 1'b0;
    cend();
    chk("busy_cyc2", busy, 1);
    cend();
    ev(5, 1'b0, 1'b1);
    chk("busy_drain", busy, 1);
    readout(1'b0, 2);
    clr_exp(); exp_c[5] = 3; exp_c[9] = 1;
    chk("a_bin5", got[5], 3);
    chk("a_bin9", got[9], 1);
    chk("a_bin255", got[255], 0);
    cmp_bins("a_bins");

    // cyc_num 0 acts as 1; adjacent and 1-apart same-bin events; final event rides on cyc_end
    do_start(0);
    ev(11, 1'b0, 1'b0);
    @(posedge clk); #1;
    ev(11, 1'b0, 1'b0);
    ev(7, 1'b0, 1'b0); ev(7, 1'b0, 1'b0); ev(7, 1'b0, 1'b0); ev(7, 1'b1, 1'b0);
    ev(7, 1'b0, 1'b1);
    readout(1'b1, 2);
    clr_exp(); exp_c[7] = 4; exp_c[11] = 2;
    chk("b_bin7", got[7], 4);
    chk("b_bin11", got[11], 2);
    cmp_bins("b_bins");

    // saturation on the 4-bit instance
    do_start(1);
    for (int i = 0; i < 19; i++) ev(0, 1'b0, 1'b0);
    ev(0, 1'b1, 1'b0);
    ev(0, 1'b0, 1'b1);
    readout(1'b1, 2);
    clr_exp(); exp_c[0] = 20;
    chk("c_bin0", got[0], 20);
    chk("c_bin0_sat", got_s[0], 15);
    cmp_bins("c_bins");

    // abort mid-accumulation, then a fresh run must hold only its own events
    do_start(2);
    ev(30, 1'b0, 1'b0); ev(30, 1'b0, 1'b0);
    res = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_rd_valid", rd_valid, 0);
    @(posedge clk); #1;
    res = 1'b0;
`ifdef HIS_PEAK_DETECT_EN
    chk("abort_peak", peak_count, 0);
`endif
    do_start(1);
    ev(2, 1'b0, 1'b0); ev(8, 1'b0, 1'b0); ev(2, 1'b0, 1'b0);
    ev(8, 1'b0, 1'b0); ev(2, 1'b0, 1'b0); ev(8, 1'b1, 1'b0);
    ev(9, 1'b0, 1'b1);
    readout(1'b1, 2);
    clr_exp(); exp_c[2] = 3; exp_c[8] = 3;
    chk("d_bin30", got[30], 0);
    chk("d_bin2", got[2], 3);
    cmp_bins("d_bins");
`ifdef HIS_PEAK_DETECT_EN
    chk("peak_bin", peak_bin, 2);
    chk("peak_count", peak_count, 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/his_builder_pp.md
HIS_BUILDER_PP -- requirements
Module: his_builder_pp

Interface
REQ-001 SHALL have parameter BIN_W, default 8: bin address width; NUM_BINS = 2**BIN_W.
REQ-002 SHALL have parameter CNT_W, default 12: per-bin counter width.
REQ-003 SHALL have parameter CYC_W, default 16: laser-cycle counter width.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port res  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  in  1  one-cycle pulse, begins a histogram acquisition.
REQ-007 SHALL have port cyc_num  in  CYC_W  laser cycles per histogram, sampled on accepted start.
REQ-008 SHALL have port cyc_end  in  1  pulse marking end of one laser cycle.
REQ-009 SHALL have port ev_valid  in  1  timestamp event present.
REQ-010 SHALL have port ev_bin  in  BIN_W  bin index of event.
REQ-011 SHALL have port rd_ready  in  1  readout sink ready.
REQ-012 SHALL have ports rd_valid out 1, rd_bin out BIN_W, rd_count out CNT_W, rd_last out 1: readout stream.
REQ-013 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-014 SHALL have port his_done  out  1  one-cycle pulse after last bin accepted.
REQ-015 SHALL have port ev_drop  out  1  one-cycle pulse per event not accumulated.

Function
REQ-016 SHALL implement states IDLE, CLEAR, ACCUM, DRAIN, READOUT.
REQ-017 IDLE: start=1 -> CLEAR next cycle, latch cyc_num (0 treated as 1); start in any other state ignored.
REQ-018 CLEAR: write 0 to bins 0..NUM_BINS-1, one per cycle, exactly NUM_BINS cycles, then ACCUM.
REQ-019 ACCUM: each ev_valid cycle increments count[ev_bin] by 1 via 2-stage read-modify-write; one event per cycle sustained.
REQ-020 Back-to-back or 1-apart events to the same bin SHALL be forwarded so every event is counted (N events -> +N).
REQ-021 Increment SHALL saturate at 2**CNT_W-1; no wrap.
REQ-022 cyc_end in ACCUM increments cycle counter; on the cyc_end making count equal latched cyc_num -> DRAIN next cycle.
REQ-023 An event coincident with the final cyc_end SHALL be accumulated; events after it SHALL be dropped.
REQ-024 DRAIN: exactly 2 cycles to retire RMW pipeline, then READOUT.
REQ-025 READOUT: present bins 0..NUM_BINS-1 in ascending order; rd_bin/rd_count/rd_last SHALL hold stable while rd_valid=1 and rd_ready=0.
REQ-026 rd_last=1 only with rd_bin=NUM_BINS-1; after that transfer (rd_valid&rd_ready) his_done pulses next cycle and state returns to IDLE.
REQ-027 First rd_valid SHALL assert within 2 cycles of entering READOUT; with rd_ready held 1, one bin per cycle thereafter.
REQ-028 ev_drop SHALL pulse (1-cycle latency) for ev_valid in any state other than ACCUM; cyc_end outside ACCUM ignored.
REQ-029 Histogram memory SHALL be a single-port-write/single-read array inferable as block RAM; no per-bin reset.

Reset
REQ-030 res=1 SHALL asynchronously force IDLE, clear cycle counter and pipeline, and drive rd_valid, rd_last, busy, his_done, ev_drop to 0, rd_bin and rd_count to 0.
REQ-031 Reset mid-operation SHALL abort; memory contents undefined until next CLEAR.

Configuration
REQ-032 Macro HIS_PEAK_DETECT_EN SHALL, when defined, add outputs peak_bin (BIN_W) and peak_count (CNT_W).
REQ-033 With it: both 0 on reset and during CLEAR; in ACCUM update when a write-back value is strictly greater than peak_count (earliest bin reaching the maximum wins ties); held through READOUT until next start.
REQ-034 Without it: ports and logic absent; all other behaviour identical.

Verification
REQ-035 Bench SHALL run cyc_num=3, events bins 5,5,5,9 then 3 cyc_end -> readout bin5=3, bin9=1, all others 0, rd_last at bin 255, his_done one pulse.
REQ-036 Bench SHALL send 4 consecutive-cycle events to bin 7 -> rd_count=4 at bin 7 (forwarding).
REQ-037 Bench SHALL use CNT_W=4 with 20 events to bin 0 -> bin 0 reads 15.
REQ-038 Bench SHALL toggle rd_ready randomly -> 256 transfers, no duplicates, outputs stable while stalled.
REQ-039 Bench SHALL assert res during ACCUM, then start again -> busy drops immediately; new histogram holds only new events.
REQ-040 Bench SHALL, with HIS_PEAK_DETECT_EN, put 3 events in bin 2 and 3 in bin 8 -> peak_bin=2, peak_count=3.
